// File: rtl/letter_code_sequencer_if.sv
// rtl/letter_code_sequencer_if.sv - letter-code push stream between producer and sequencer
interface letter_code_sequencer_if;
    logic [5:0] in_code;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_code, output in_valid, input in_ready);
    modport slave  (input in_code, input in_valid, output in_ready);
endinterface

// File: rtl/letter_code_sequencer.sv
// rtl/letter_code_sequencer.sv - buffers letter codes and presents each on A..F for HOLD cycles
module letter_code_sequencer #(
    parameter int         DEPTH     = 4,
    parameter int         HOLD      = 2,
    parameter logic [5:0] IDLE_CODE = 6'b000001
) (
    input  logic                    clock,
    input  logic                    reset,
    letter_code_sequencer_if.slave  in_if,
    input  logic                    clear_counts_i,
    input  logic                    valid_i,
    input  logic                    vowel_i,
    output logic                    a_o,
    output logic                    b_o,
    output logic                    c_o,
    output logic                    d_o,
    output logic                    e_o,
    output logic                    f_o,
    output logic                    code_strobe_o,
    output logic                    sending_o,
    output logic [7:0]              word_count_o,
    output logic [7:0]              vowel_count_o,
    output logic [7:0]              invalid_count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [0:0]    ST_IDLE    = 1'b0;
    localparam logic [0:0]    ST_PRESENT = 1'b1;
    localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
    localparam logic [HW-1:0] LAST_HOLD  = HW'(HOLD - 1);

    logic [5:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [0:0]    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [5:0]    code_q, code_d;
    logic [7:0]    word_q, word_d, vowel_q, vowel_d, invalid_q, invalid_d;
    logic          full, empty, push, pop, strobe;

    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign push   = in_if.in_valid && !full;
    assign strobe = (state_q == ST_PRESENT) && (hold_q == LAST_HOLD);
    // The head is taken either from idle or exactly at the strobe, giving gap-free back-to-back words.
    assign pop    = !empty && ((state_q == ST_IDLE) || strobe);

    assign in_if.in_ready = !full;
    assign {a_o, b_o, c_o, d_o, e_o, f_o} = code_q;
    assign code_strobe_o   = strobe;
    assign sending_o       = (state_q == ST_PRESENT);
    assign word_count_o    = word_q;
    assign vowel_count_o   = vowel_q;
    assign invalid_count_o = invalid_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        code_d  = code_q;
        if (pop) begin
            state_d = ST_PRESENT;
            hold_d  = '0;
            code_d  = mem_q[rd_ptr_q];
        end else if (strobe) begin
            state_d = ST_IDLE;
            hold_d  = '0;
            code_d  = IDLE_CODE;
        end else if (state_q == ST_PRESENT) begin
            hold_d = hold_q + HW'(1);
        end
    end

    always_comb begin
        word_d    = word_q;
        vowel_d   = vowel_q;
        invalid_d = invalid_q;
        if (clear_counts_i) begin
            word_d    = '0;
            vowel_d   = '0;
            invalid_d = '0;
        end else if (strobe) begin
            if (word_q != 8'hFF) word_d = word_q + 8'd1;
            // A vowel flag without a valid decode is noise and is only counted as invalid.
            if (valid_i && vowel_i && (vowel_q != 8'hFF)) vowel_d = vowel_q + 8'd1;
            if (!valid_i && (invalid_q != 8'hFF)) invalid_d = invalid_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_if.in_code;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            code_q    <= IDLE_CODE;
            word_q    <= '0;
            vowel_q   <= '0;
            invalid_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            code_q    <= code_d;
            word_q    <= word_d;
            vowel_q   <= vowel_d;
            invalid_q <= invalid_d;
        end
    end
endmodule

// File: tb/tb_letter_code_sequencer.sv
// tb/tb_letter_code_sequencer.sv - randomized bench for letter_code_sequencer against a queue model
module tb_letter_code_sequencer;
    localparam logic [5:0] IDLE = 6'b000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference decoder: codes 2..27 are letters, vowels A,E,I,O,U; 40 and 50 raise vowel without valid.
    function automatic logic [1:0] decode(input logic [5:0] c);
        logic v, w;
        v = (c >= 6'd2) && (c <= 6'd27);
        w = c inside {6'd2, 6'd6, 6'd10, 6'd16, 6'd22, 6'd40, 6'd50};
        return {v, w};
    endfunction

    letter_code_sequencer_if if0();
    letter_code_sequencer_if if1();

    logic clr0, val0, vow0, a0, b0, c0, d0, e0, f0, strobe0, sending0;
    logic [7:0] wc0, vc0, ic0;
    logic [5:0] code0;
    logic val1, vow1, a1, b1, c1, d1, e1, f1, strobe1, sending1;
    logic [7:0] wc1, vc1, ic1;
    logic [5:0] code1;

    assign code0 = {a0, b0, c0, d0, e0, f0};
    assign code1 = {a1, b1, c1, d1, e1, f1};
    assign {val0, vow0} = decode(code0);
    assign {val1, vow1} = decode(code1);

    letter_code_sequencer #(.DEPTH(4), .HOLD(2), .IDLE_CODE(IDLE)) u_dut0 (
        .clock(clk), .reset(rst), .in_if(if0), .clear_counts_i(clr0),
        .valid_i(val0), .vowel_i(vow0),
        .a_o(a0), .b_o(b0), .c_o(c0), .d_o(d0), .e_o(e0), .f_o(f0),
        .code_strobe_o(strobe0), .sending_o(sending0),
        .word_count_o(wc0), .vowel_count_o(vc0), .invalid_count_o(ic0)
    );

    letter_code_sequencer #(.DEPTH(4), .HOLD(1), .IDLE_CODE(IDLE)) u_dut1 (
        .clock(clk), .reset(rst), .in_if(if1), .clear_counts_i(1'b0),
        .valid_i(val1), .vowel_i(vow1),
        .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1), .e_o(e1), .f_o(f1),
        .code_strobe_o(strobe1), .sending_o(sending1),
        .word_count_o(wc1), .vowel_count_o(vc1), .invalid_count_o(ic1)
    );

    logic [5:0] exp0[$], obs0[$], exp1[$], obs1[$];
    int runs0[$], sruns1[$];
    int run_len0 = 0, hold_cnt0 = 0, hold_err0 = 0, full_pop0 = 0, srun1 = 0;

    always @(negedge clk) begin
        if (rst) begin
            run_len0 = 0; hold_cnt0 = 0; srun1 = 0;
        end else begin
            if (strobe0) begin
                obs0.push_back(code0);
                if (hold_cnt0 + 1 != 2) hold_err0++;
                hold_cnt0 = 0;
            end else if (sending0) begin
                hold_cnt0++;
            end
            if (sending0) run_len0++;
            else if (run_len0 > 0) begin runs0.push_back(run_len0); run_len0 = 0; end
            if (!if0.in_ready && strobe0) full_pop0++;
            if (strobe1) begin obs1.push_back(code1); srun1++; end
            else if (srun1 > 0) begin sruns1.push_back(srun1); srun1 = 0; end
        end
    end

    task automatic push0(input logic [5:0] c, output bit stalled);
        int n = 0;
        stalled = 0;
        if0.in_code = c;
        if0.in_valid = 1'b1;
        @(negedge clk);
        while (!if0.in_ready && n < 300) begin stalled = 1; n++; @(negedge clk); end
        checks++;
        if (!if0.in_ready) begin
            failures++; $display("FAIL push0_timeout in_ready=%0b required=1", if0.in_ready);
        end else exp0.push_back(c);
        @(posedge clk); #1;
    endtask

    task automatic push1(input logic [5:0] c);
        int n = 0;
        if1.in_code = c;
        if1.in_valid = 1'b1;
        @(negedge clk);
        while (!if1.in_ready && n < 300) begin n++; @(negedge clk); end
        checks++;
        if (!if1.in_ready) begin
            failures++; $display("FAIL push1_timeout in_ready=%0b required=1", if1.in_ready);
        end else exp1.push_back(c);
        @(posedge clk); #1;
    endtask

    task automatic drain0();
        int n = 0;
        while ((obs0.size() < exp0.size() || sending0) && n < 2000) begin @(posedge clk); #1; n++; end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (n >= 2000) begin
            failures++; $display("FAIL drain0_timeout seen=%0d required=%0d", obs0.size(), exp0.size());
        end
    endtask

    task automatic start0();
        if0.in_valid = 1'b0;
        clr0 = 1'b1;
        @(posedge clk); #1;
        clr0 = 1'b0;
        exp0.delete(); obs0.delete(); runs0.delete();
        hold_err0 = 0; full_pop0 = 0;
    endtask

    task automatic model_counts(output int w, output int v, output int i);
        logic [1:0] r;
        w = 0; v = 0; i = 0;
        foreach (exp0[k]) begin
            r = decode(exp0[k]);
            w = (w < 255) ? w + 1 : 255;
            if (r == 2'b11) v = (v < 255) ? v + 1 : 255;
            if (!r[1]) i = (i < 255) ? i + 1 : 255;
        end
    endtask

    task automatic compare_seq0(input string name);
        checks++;
        if (obs0.size() != exp0.size()) begin
            failures++; $display("FAIL %s_len got=%0d required=%0d", name, obs0.size(), exp0.size());
        end else begin
            foreach (exp0[k]) begin
                checks++;
                if (obs0[k] !== exp0[k]) begin
                    failures++; $display("FAIL %s_word%0d got=%b required=%b", name, k, obs0[k], exp0[k]);
                end
            end
        end
    endtask

    task automatic test_reset();
        bit st;
        @(posedge clk); #1;
        checks++;
        if ({code0, if0.in_ready, sending0, strobe0, wc0, vc0, ic0} !== {IDLE, 1'b1, 1'b0, 1'b0, 24'd0}) begin
            failures++; $display("FAIL reset_state code=%b rdy=%b snd=%b stb=%b", code0, if0.in_ready, sending0, strobe0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        push0(6'd5, st); push0(6'd6, st); push0(6'd7, st); push0(6'd8, st);
        if0.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({code0, if0.in_ready, sending0, wc0, vc0, ic0} !== {IDLE, 1'b1, 1'b0, 24'd0}) begin
            failures++; $display("FAIL reset_midword code=%b rdy=%b snd=%b wc=%0d", code0, if0.in_ready, sending0, wc0);
        end
        exp0.delete(); obs0.delete(); runs0.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (obs0.size() != 0 || sending0 !== 1'b0) begin
            failures++; $display("FAIL reset_stale strobes=%0d sending=%b required 0 and 0", obs0.size(), sending0);
        end
    endtask

    task automatic test_single();
        bit st;
        start0();
        push0(6'b000010, st);
        if0.in_valid = 1'b0;
        checks++;
        if (code0 !== IDLE || sending0 !== 1'b0) begin
            failures++; $display("FAIL single_e0 code=%b snd=%b required=%b 0", code0, sending0, IDLE);
        end
        @(posedge clk); #1;
        checks++;
        if ({code0, sending0, strobe0} !== {6'b000010, 1'b1, 1'b0}) begin
            failures++; $display("FAIL single_e1 code=%b snd=%b stb=%b required=000010 1 0", code0, sending0, strobe0);
        end
        @(posedge clk); #1;
        checks++;
        if ({code0, strobe0} !== {6'b000010, 1'b1}) begin
            failures++; $display("FAIL single_e2 code=%b stb=%b required=000010 1", code0, strobe0);
        end
        @(posedge clk); #1;
        checks++;
        if ({code0, sending0, wc0, vc0, ic0} !== {IDLE, 1'b0, 8'd1, 8'd1, 8'd0}) begin
            failures++; $display("FAIL single_e3 code=%b snd=%b wc=%0d vc=%0d ic=%0d required=000001 0 1 1 0", code0, sending0, wc0, vc0, ic0);
        end
    endtask

    task automatic test_back_to_back();
        bit st;
        bit any_stall = 0;
        logic [5:0] words [4] = '{6'b000101, 6'b111101, 6'b000001, 6'b011011};
        start0();
        foreach (words[k]) begin push0(words[k], st); any_stall |= st; end
        if0.in_valid = 1'b0;
        drain0();
        checks++;
        if (any_stall) begin failures++; $display("FAIL b2b_ready got=stalled required=no_stall"); end
        compare_seq0("b2b");
        checks++;
        if (runs0.size() != 1 || runs0[0] != 8) begin
            failures++; $display("FAIL b2b_gapless runs=%0d first=%0d required=1 8", runs0.size(), (runs0.size() > 0) ? runs0[0] : 0);
        end
        checks++;
        if ({wc0, vc0, ic0, hold_err0} !== {8'd4, 8'd0, 8'd2, 32'd0}) begin
            failures++; $display("FAIL b2b_counts wc=%0d vc=%0d ic=%0d holderr=%0d required=4 0 2 0", wc0, vc0, ic0, hold_err0);
        end
    endtask

    task automatic test_full();
        bit st;
        bit any_stall = 0;
        int w, v, i;
        start0();
        for (int k = 0; k < 12; k++) begin push0(6'($urandom_range(0, 63)), st); any_stall |= st; end
        if0.in_valid = 1'b0;
        drain0();
        checks++;
        if (!any_stall || full_pop0 == 0) begin
            failures++; $display("FAIL full_backpressure stall=%0b ready_low_on_pop=%0d required=1 >0", any_stall, full_pop0);
        end
        compare_seq0("full");
        model_counts(w, v, i);
        checks++;
        if (wc0 != 8'(w) || vc0 != 8'(v) || ic0 != 8'(i) || hold_err0 != 0) begin
            failures++; $display("FAIL full_counts wc=%0d vc=%0d ic=%0d required=%0d %0d %0d", wc0, vc0, ic0, w, v, i);
        end
    endtask

    task automatic test_random();
        bit st;
        int w, v, i;
        start0();
        for (int k = 0; k < 40; k++) begin
            push0(6'($urandom_range(0, 63)), st);
            if ($urandom_range(0, 1) == 1) begin
                if0.in_valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        if0.in_valid = 1'b0;
        drain0();
        compare_seq0("random");
        model_counts(w, v, i);
        checks++;
        if (wc0 != 8'(w) || vc0 != 8'(v) || ic0 != 8'(i) || hold_err0 != 0) begin
            failures++; $display("FAIL random_counts wc=%0d vc=%0d ic=%0d holderr=%0d required=%0d %0d %0d 0", wc0, vc0, ic0, hold_err0, w, v, i);
        end
    endtask

    task automatic test_saturation();
        bit st;
        int n;
        start0();
        for (int k = 0; k < 300; k++) push0(IDLE, st);
        if0.in_valid = 1'b0;
        drain0();
        checks++;
        if ({wc0, vc0, ic0} !== {8'd255, 8'd0, 8'd255}) begin
            failures++; $display("FAIL sat_counts wc=%0d vc=%0d ic=%0d required=255 0 255", wc0, vc0, ic0);
        end
        push0(6'd2, st); push0(6'd2, st);
        if0.in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!strobe0 && n < 20) begin n++; @(negedge clk); end
        clr0 = 1'b1;
        @(posedge clk); #1;
        clr0 = 1'b0;
        checks++;
        if ({wc0, vc0, ic0} !== 24'd0 || n >= 20) begin
            failures++; $display("FAIL clear_wins wc=%0d vc=%0d ic=%0d required=0 0 0", wc0, vc0, ic0);
        end
        n = 0;
        @(negedge clk);
        while (!strobe0 && n < 20) begin n++; @(negedge clk); end
        @(posedge clk); #1;
        checks++;
        if ({wc0, vc0, ic0} !== {8'd1, 8'd1, 8'd0}) begin
            failures++; $display("FAIL clear_restart wc=%0d vc=%0d ic=%0d required=1 1 0", wc0, vc0, ic0);
        end
    endtask

    task automatic test_hold1();
        logic [5:0] c, prev;
        int n = 0;
        exp1.delete(); obs1.delete(); sruns1.delete();
        prev = IDLE;
        for (int k = 0; k < 5; k++) begin
            c = 6'($urandom_range(0, 63));
            if (c == prev || c == IDLE) c = c ^ 6'b100010;
            push1(c);
            prev = c;
        end
        if1.in_valid = 1'b0;
        while ((obs1.size() < 5 || sending1) && n < 100) begin @(posedge clk); #1; n++; end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sruns1.size() != 1 || sruns1[0] != 5) begin
            failures++; $display("FAIL hold1_strobe_run runs=%0d first=%0d required=1 5", sruns1.size(), (sruns1.size() > 0) ? sruns1[0] : 0);
        end
        checks++;
        if (obs1.size() != 5) begin
            failures++; $display("FAIL hold1_len got=%0d required=5", obs1.size());
        end else begin
            foreach (exp1[k]) begin
                checks++;
                if (obs1[k] !== exp1[k]) begin
                    failures++; $display("FAIL hold1_word%0d got=%b required=%b", k, obs1[k], exp1[k]);
                end
            end
        end
        checks++;
        if (code1 !== IDLE || wc1 !== 8'd5) begin
            failures++; $display("FAIL hold1_end code=%b wc=%0d required=%b 5", code1, wc1, IDLE);
        end
    endtask

    initial begin
        if0.in_valid = 1'b0; if0.in_code = '0;
        if1.in_valid = 1'b0; if1.in_code = '0;
        clr0 = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_random();
        test_saturation();
        test_hold1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
